led_blink_seq: RTL and testbench

Output-side companion to the key debouncer: converts one-cycle event pulses, such as key-press flags or STM32/SPI command strobes, into human-visible LED blink sequences. Each of N independent channels plays a programmable pattern on a trigger pulse: BLINKS repetitions of ON_MS on and OFF_MS off. All channels share one free-running millisecond tick prescaler. It sits between the event logic and the board LED pins, which are active-low.

---
 rtl/led_blink_seq.sv | 187 ++++++++++++++++++
 tb/tb_led_blink_seq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/led_blink_seq.sv
// rtl/led_blink_seq.sv - per-channel LED blink sequencer driven by one-cycle trigger pulses
// Shared millisecond prescaler feeds N independent IDLE/ON/OFF channels with active-low registered outputs.

module led_blink_tick #(
    parameter int TICK_DIV = 50_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] CNT_MAX = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] CNT_ONE = PW'(1);

    logic [PW-1:0] cnt;

    // Free-running: triggers never realign the tick, so the first ON phase may be short.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_ONE;
        end
    end

    assign tick = (cnt == CNT_MAX);
endmodule

module led_blink_chan #(
    parameter int ON_MS  = 100,
    parameter int OFF_MS = 100,
    parameter int BLINKS = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic trig,
    output logic led_n,
    output logic busy
);
    localparam int PC_MAX = (ON_MS > OFF_MS) ? ON_MS : OFF_MS;
    localparam int PCW    = $clog2(PC_MAX + 1);
    localparam int BW     = $clog2(BLINKS + 1);

    localparam logic [PCW-1:0] PC_ON  = PCW'(ON_MS);
    localparam logic [PCW-1:0] PC_OFF = PCW'(OFF_MS);
    localparam logic [PCW-1:0] PC_ONE = PCW'(1);
    localparam logic [BW-1:0]  BC_LD  = BW'(BLINKS);
    localparam logic [BW-1:0]  BC_ONE = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t         state, state_d;
    logic [PCW-1:0] pc, pc_d;
    logic [BW-1:0]  bc, bc_d;
    logic           led_n_d;
    logic           busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
            bc    <= '0;
            led_n <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            bc    <= bc_d;
            led_n <= led_n_d;
            busy  <= busy_d;
        end
    end

    // A trigger always wins over a coincident tick: the counters load and that tick is dropped.
    always_comb begin
        state_d = state;
        pc_d    = pc;
        bc_d    = bc;
        if (trig) begin
            state_d = S_ON;
            pc_d    = PC_ON;
            bc_d    = BC_LD;
        end else begin
            case (state)
                S_ON: begin
                    if (tick) begin
                        if (pc == PC_ONE) begin
                            if (bc == BC_ONE) begin
                                state_d = S_IDLE;
                                pc_d    = '0;
                                bc_d    = '0;
                            end else begin
                                state_d = S_OFF;
                                pc_d    = PC_OFF;
                                bc_d    = bc - BC_ONE;
                            end
                        end else begin
                            pc_d = pc - PC_ONE;
                        end
                    end
                end
                S_OFF: begin
                    if (tick) begin
                        if (pc == PC_ONE) begin
                            state_d = S_ON;
                            pc_d    = PC_ON;
                        end else begin
                            pc_d = pc - PC_ONE;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Outputs decode the next state so the registered pins change on the same edge as the FSM.
    always_comb begin
        led_n_d = 1'b1;
        busy_d  = 1'b0;
        case (state_d)
            S_ON: begin
                led_n_d = 1'b0;
                busy_d  = 1'b1;
            end
            S_OFF: begin
                led_n_d = 1'b1;
                busy_d  = 1'b1;
            end
            default: begin
                led_n_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end
endmodule

module led_blink_seq #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 1000,
    parameter int N       = 4,
    parameter int ON_MS   = 100,
    parameter int OFF_MS  = 100,
    parameter int BLINKS  = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] trig,
    output logic [N-1:0] led_n,
    output logic [N-1:0] busy
);
    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    logic tick;

    led_blink_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    for (genvar g = 0; g < N; g++) begin : g_chan
        led_blink_chan #(
            .ON_MS (ON_MS),
            .OFF_MS(OFF_MS),
            .BLINKS(BLINKS)
        ) u_chan (
            .clk  (clk),
            .rst_n(rst_n),
            .tick (tick),
            .trig (trig[g]),
            .led_n(led_n[g]),
            .busy (busy[g])
        );
    end
endmodule

// File: tb/tb_led_blink_seq.sv
// tb/tb_led_blink_seq.sv - directed scoreboard bench for led_blink_seq
module tb_led_blink_seq;
    localparam int TD       = 10;
    localparam int ON_MS    = 2;
    localparam int OFF_MS   = 1;
    localparam int BLINKS   = 2;
    localparam int ON_C     = ON_MS * TD;
    localparam int OFF_C    = OFF_MS * TD;
    localparam int SEQ_TAIL = (BLINKS - 1) * (ON_C + OFF_C);

    typedef struct {
        logic [3:0] led;
        logic [3:0] busy;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] trig = 4'h0;
    logic [3:0] led_n;
    logic [3:0] busy;

    exp_t  sb[$];
    string cur_tag = "reset";
    int    errors = 0;
    int    checks = 0;
    int    presc = 0;
    bit    act[4];
    int    tt[4];
    int    l1[4];

    led_blink_seq #(
        .CLK_HZ (TD * 1000),
        .TICK_HZ(1000),
        .N      (4),
        .ON_MS  (ON_MS),
        .OFF_MS (OFF_MS),
        .BLINKS (BLINKS)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .trig (trig),
        .led_n(led_n),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk({cur_tag, " scoreboard_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({cur_tag, " led_n"}, {28'd0, led_n}, {28'd0, e.led});
            chk({cur_tag, " busy"}, {28'd0, busy}, {28'd0, e.busy});
        end
    endtask

    // Spec-level timing: first ON lasts up to the second tick, then exact OFF/ON phases.
    function automatic bit lit(input int t, input int first);
        int r;
        if (t < first) return 1'b1;
        r = (t - first) % (OFF_C + ON_C);
        return (r >= OFF_C);
    endfunction

    task automatic step(input logic [3:0] tr);
        exp_t e;
        int   p;
        trig = tr;
        p = presc;
        for (int c = 0; c < 4; c++) begin
            if (!rst_n) begin
                act[c] = 1'b0;
            end else if (tr[c]) begin
                act[c] = 1'b1;
                tt[c]  = 0;
                l1[c]  = (p == TD - 1) ? ON_C : ON_C - 1 - p;
            end else if (act[c]) begin
                tt[c]++;
                if (tt[c] >= l1[c] + SEQ_TAIL) act[c] = 1'b0;
            end
            e.busy[c] = act[c];
            e.led[c]  = act[c] ? !lit(tt[c], l1[c]) : 1'b1;
        end
        sb.push_back(e);
        @(posedge clk);
        presc = rst_n ? (p + 1) % TD : 0;
        #1;
        trig = 4'h0;
        pop_check();
    endtask

    task automatic wait_presc(input int v);
        for (int i = 0; i < TD && presc != v; i++) step(4'h0);
    endtask

    initial begin
        exp_t e;
        int   n_busy;
        int   n_lit;

        cur_tag = "reset_hold";
        step(4'hF);
        step(4'h0);
        step(4'h5);
        step(4'hA);
        rst_n = 1'b1;
        cur_tag = "reset_release";
        repeat (5) step(4'h0);

        cur_tag = "single";
        wait_presc(TD - 1);
        n_busy = 0;
        n_lit  = 0;
        step(4'h1);
        if (busy[0]) n_busy++;
        if (!led_n[0]) n_lit++;
        for (int i = 0; i < 60; i++) begin
            step(4'h0);
            if (busy[0]) n_busy++;
            if (!led_n[0]) n_lit++;
        end
        chk("single busy_cycles", n_busy, 50);
        chk("single lit_cycles", n_lit, 40);

        cur_tag = "retrigger";
        wait_presc(3);
        step(4'h2);
        repeat (24) step(4'h0);
        step(4'h2);
        repeat (60) step(4'h0);

        cur_tag = "trig_on_tick";
        wait_presc(TD - 1);
        step(4'h4);
        repeat (55) step(4'h0);

        cur_tag = "simultaneous";
        wait_presc(5);
        step(4'hF);
        for (int i = 0; i < 200 && act[3]; i++) step(4'h0);
        cur_tag = "back_to_back";
        step(4'h8);
        repeat (20) step(4'h0);
        repeat (40) step(4'h0);

        cur_tag = "reset_mid";
        step(4'h1);
        repeat (5) step(4'h0);
        rst_n = 1'b0;
        for (int c = 0; c < 4; c++) act[c] = 1'b0;
        presc = 0;
        e.led  = 4'hF;
        e.busy = 4'h0;
        sb.push_back(e);
        #1;
        pop_check();
        repeat (3) step(4'h0);
        rst_n = 1'b1;
        cur_tag = "after_reset";
        repeat (25) step(4'h0);
        cur_tag = "after_reset_trig";
        step(4'h1);
        repeat (55) step(4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
